barcodescanner_nios_pio_out: RTL
================================

BARCODESCANNER_NIOS_PIO_OUT -- requirements
Module: barcodescanner_nios_pio_out

Interface
REQ-001 The block SHALL have parameter RESET_VALUE, default 8'h00, giving the out_port value after reset.
REQ-002 The block SHALL have parameter STROBE_CYCLES, default 2, range 1..15, giving the out_strobe pulse width in clk cycles.
REQ-003 The block SHALL have parameter TIMEOUT_RESET, default 16'hFFFF, giving the TIMEOUT register value after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit: Avalon-MM select.
REQ-008 The block SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-009 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, 8 bits: registered data driven to the external device.
REQ-012 The block SHALL have port out_strobe, output, 1 bit: data-valid pulse to the device.
REQ-013 The block SHALL have port out_ack, input, 1 bit: device acknowledge, synchronous to clk.

Function
REQ-014 A write SHALL be defined as chipselect=1 and write_n=0 in a cycle; writes SHALL have zero wait states.
REQ-015 Register map: 0 DATA (rw, [7:0]); 1 STATUS (r, w1c); 2 TIMEOUT (rw, [15:0]); 4 OUTSET (w); 5 OUTCLR (w); reads of 3, 6, 7 and of write-only addresses SHALL return 0.
REQ-016 readdata SHALL be reloaded every clk from the mux selected by address, regardless of chipselect, giving 1-cycle read latency; unused upper bits SHALL be 0.
REQ-017 STATUS bits: [0] busy (state != IDLE); [1] overrun (sticky); [2] timeout (sticky); [3] done (sticky, set on ack). Writing 1 to bits [3:1] SHALL clear them; bit 0 is read-only.
REQ-018 FSM states: IDLE, STROBE, WAIT_ACK.
REQ-019 In IDLE, a DATA write at cycle N SHALL load out_port from writedata[7:0] at N+1, enter STROBE, and drive out_strobe=1 for cycles N+1..N+STROBE_CYCLES.
REQ-020 From STROBE, after STROBE_CYCLES cycles the FSM SHALL enter WAIT_ACK with out_strobe=0, and SHALL load a 16-bit down-counter from TIMEOUT.
REQ-021 out_ack SHALL be sampled only in WAIT_ACK; ack=1 SHALL return the FSM to IDLE on the next cycle and set done.
REQ-022 In WAIT_ACK with ack=0, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL go to IDLE and set timeout; TIMEOUT=0 SHALL mean wait indefinitely.
REQ-023 If ack=1 in the same cycle the counter expires, ack SHALL win: done set, timeout not set.
REQ-024 A DATA write while busy SHALL be ignored (out_port unchanged, no new strobe) and SHALL set overrun.
REQ-025 OUTSET/OUTCLR writes SHALL OR/AND-NOT writedata[7:0] into out_port at N+1 in IDLE only, without a strobe; while busy they SHALL be ignored and SHALL set overrun.
REQ-026 A sticky-bit set and a w1c clear of the same bit in the same cycle SHALL leave the bit set.
REQ-027 A TIMEOUT write SHALL be accepted in any state; it SHALL affect only the next counter load.

Reset
REQ-028 On reset_n=0, the block SHALL asynchronously set out_port=RESET_VALUE, out_strobe=0, readdata=0, STATUS=0, TIMEOUT=TIMEOUT_RESET, and state IDLE; reset mid-transfer SHALL abort it with no flag set.
REQ-029 Reset deassertion SHALL be synchronous to clk; the first write SHALL be honoured on the first cycle after deassertion.

Verification
REQ-030 Write DATA=0xA5, ack held high -> out_port=0xA5 at N+1; strobe high N+1..N+2; IDLE at N+4; STATUS reads 0x8.
REQ-031 TIMEOUT=3, write DATA=0x3C, ack=0 -> WAIT_ACK for 3 cycles, then IDLE; STATUS=0x4; write STATUS=0x4 -> STATUS=0x0.
REQ-032 While busy, write DATA=0x11 -> out_port keeps its previous value, no extra strobe, STATUS bit1=1.
REQ-033 In IDLE with out_port=0xF0: OUTSET 0x0F -> 0xFF; OUTCLR 0x81 -> 0x7E; out_strobe stays 0.
REQ-034 TIMEOUT=2, ack rises in the cycle the counter hits 0 -> done=1, timeout=0.
REQ-035 Assert reset_n=0 during STROBE -> out_strobe=0 and out_port=RESET_VALUE immediately; STATUS=0 after release.

Source files
------------

// File: rtl/barcodescanner_nios_pio_out.sv
// Avalon-MM output PIO for the barcode scanner. It drives an 8-bit port to the
// external device with a strobe, then waits for the device to acknowledge or
// for a programmable timeout to run out. Write-1-to-clear sticky status bits
// record completion, timeout and writes that arrive while a transfer is busy.
module barcodescanner_nios_pio_out #(
    parameter logic [7:0]  RESET_VALUE   = 8'h00,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter logic [15:0] TIMEOUT_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        out_strobe,
    input  logic        out_ack
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK} state_t;

    // Strobe counter counts down to 0; loaded with width-1 when a transfer starts.
    localparam logic [3:0] SC_M1 = 4'(STROBE_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  scnt;
    logic [15:0] tcnt;
    logic [15:0] timeout_r;
    logic        ovr, tmo, done;
    logic        start, set_done, set_to, set_ovr, busy;
    logic        wr, wr_data, wr_status, wr_tmo, wr_set, wr_clr;
    logic [2:0]  clr;
    logic [31:0] rd_mux;
    logic        unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr && (address == 3'd0);
    assign wr_status = wr && (address == 3'd1);
    assign wr_tmo    = wr && (address == 3'd2);
    assign wr_set    = wr && (address == 3'd4);
    assign wr_clr    = wr && (address == 3'd5);
    assign busy      = (state != IDLE);
    assign set_ovr   = busy & (wr_data | wr_set | wr_clr);
    assign clr       = wr_status ? writedata[3:1] : 3'b000;
    assign out_strobe = (state == STROBE);
    assign unused_wd = ^writedata[31:16];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: ack beats an expiring counter; tcnt==0 never expires.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        set_done = 1'b0;
        set_to   = 1'b0;
        case (state)
            IDLE: if (wr_data) begin
                state_nx = STROBE;
                start    = 1'b1;
            end
            STROBE: if (scnt == 4'd0) state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (out_ack) begin
                    state_nx = IDLE;
                    set_done = 1'b1;
                end else if (tcnt == 16'd1) begin
                    state_nx = IDLE;
                    set_to   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobe width counter and ack timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt <= 4'd0;
            tcnt <= 16'd0;
        end else begin
            if (start)
                scnt <= SC_M1;
            else if (state == STROBE && scnt != 4'd0)
                scnt <= scnt - 4'd1;
            if (state == STROBE && scnt == 4'd0)
                tcnt <= timeout_r;
            else if (state == WAIT_ACK && tcnt != 16'd0)
                tcnt <= tcnt - 16'd1;
        end
    end

    // Port data and timeout register; port changes only from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port  <= RESET_VALUE;
            timeout_r <= TIMEOUT_RESET;
        end else begin
            if (!busy) begin
                if (wr_data)     out_port <= writedata[7:0];
                else if (wr_set) out_port <= out_port | writedata[7:0];
                else if (wr_clr) out_port <= out_port & ~writedata[7:0];
            end
            if (wr_tmo) timeout_r <= writedata[15:0];
        end
    end

    // Sticky status bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr  <= 1'b0;
            tmo  <= 1'b0;
            done <= 1'b0;
        end else begin
            ovr  <= set_ovr  | (ovr  & ~clr[0]);
            tmo  <= set_to   | (tmo  & ~clr[1]);
            done <= set_done | (done & ~clr[2]);
        end
    end

    // Read mux, independent of chipselect.
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0:    rd_mux = {24'd0, out_port};
            3'd1:    rd_mux = {28'd0, done, tmo, ovr, busy};
            3'd2:    rd_mux = {16'd0, timeout_r};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read data, one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 32'd0;
        else          readdata <= rd_mux;
    end

endmodule
